var_shift_unit: RTL and testbench

VAR_SHIFT_UNIT -- requirements
Module: var_shift_unit

---
 rtl/var_shift_pkg.sv | 23 ++
 rtl/var_shift_unit_if.sv | 28 ++
 rtl/var_shift_stage.sv | 66 ++++++
 rtl/var_shift_unit.sv | 74 +++++++
 tb/tb_var_shift_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/var_shift_pkg.sv
// Shared types for the variable shifter: mode encoding, per-op metadata, stage split.
// No logic and no latency here.
// No backpressure here; the handshake lives in var_shift_unit.
package var_shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'd0,
    MODE_SRL = 2'd1,
    MODE_SRA = 2'd2,
    MODE_ROL = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e mode;
    logic  err;
  } meta_t;

  // Amount bits handled by the first stage; the second stage takes the rest.
  function automatic int split_bits(input int width);
    return $clog2(width) / 2;
  endfunction

endpackage

// File: rtl/var_shift_unit_if.sv
// Operation/result handshake bundle for var_shift_unit.
// No latency; wires only.
// valid/ready on both sides; master drives operations and consumes results.
interface var_shift_unit_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_err
  );
endinterface

// File: rtl/var_shift_stage.sv
// One registered partial shift by in_sh; amounts >= WIDTH saturate (ROL wraps, VAR_SHIFT_ROTATE_EN).
// Latency 1 cycle.
// Holds its register whenever advance is low.
module var_shift_stage
  import var_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [AMT_W-1:0] in_sh,
  input  meta_t            in_meta,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [AMT_W-1:0] out_amt,
  output meta_t            out_meta
);
  logic [31:0]      sh32;
  logic             ovf;
  logic [WIDTH-1:0] res;
`ifdef VAR_SHIFT_ROTATE_EN
  logic [31:0]        rot_amt;
  logic [2*WIDTH-1:0] dbl;
`endif

  always_comb begin
    sh32 = 32'(in_sh);
    ovf  = (sh32 >= WIDTH);
`ifdef VAR_SHIFT_ROTATE_EN
    // Shifting a doubled copy keeps rotation exact for non-power-of-two widths.
    rot_amt = sh32 % WIDTH;
    dbl     = {in_data, in_data} << rot_amt;
`endif
    case (in_meta.mode)
      MODE_SRL: res = ovf ? '0 : (in_data >> in_sh);
      MODE_SRA: res = ovf ? {WIDTH{in_data[WIDTH-1]}}
                          : $unsigned($signed(in_data) >>> in_sh);
`ifdef VAR_SHIFT_ROTATE_EN
      MODE_ROL: res = dbl[2*WIDTH-1:WIDTH];
`endif
      default:  res = ovf ? '0 : (in_data << in_sh);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_meta  <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= res;
        out_amt  <= in_amt;
        out_meta <= in_meta;
      end
    end
  end

endmodule

// File: rtl/var_shift_unit.sv
// SLL/SRL/SRA/ROL variable shifter; ROL only with VAR_SHIFT_ROTATE_EN, else mode 3 = SLL + out_err.
// Latency 2 cycles, one op per cycle sustained.
// in_ready drops only when both stages are full and the output is stalled.
module var_shift_unit
  import var_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  var_shift_unit_if.slave bus
);
  localparam int               LO_BITS = split_bits(WIDTH);
  localparam logic [AMT_W-1:0] LO_MASK = AMT_W'((1 << LO_BITS) - 1);

  logic             s1_valid, s2_valid;
  logic             s1_advance, s2_advance;
  logic [WIDTH-1:0] s1_data, s2_data;
  logic [AMT_W-1:0] s1_amt, s2_amt;
  meta_t            in_meta, s1_meta, s2_meta;
  logic             unused_s2;

  assign s2_advance  = !s2_valid || bus.out_ready;
  assign s1_advance  = !s1_valid || s2_advance;
  assign bus.in_ready = s1_advance;

  always_comb begin
    in_meta.mode = mode_e'(bus.in_mode);
`ifdef VAR_SHIFT_ROTATE_EN
    in_meta.err  = 1'b0;
`else
    in_meta.err  = (bus.in_mode == 2'd3);
`endif
  end

  var_shift_stage #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_stage1 (
    .clk       (clk),
    .reset     (reset),
    .advance   (s1_advance),
    .in_valid  (bus.in_valid),
    .in_data   (bus.in_data),
    .in_amt    (bus.in_amt),
    .in_sh     (bus.in_amt & LO_MASK),
    .in_meta   (in_meta),
    .out_valid (s1_valid),
    .out_data  (s1_data),
    .out_amt   (s1_amt),
    .out_meta  (s1_meta)
  );

  // Stage 2 sees the full remaining amount, so it owns the saturation rules.
  var_shift_stage #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_stage2 (
    .clk       (clk),
    .reset     (reset),
    .advance   (s2_advance),
    .in_valid  (s1_valid),
    .in_data   (s1_data),
    .in_amt    (s1_amt),
    .in_sh     (s1_amt & ~LO_MASK),
    .in_meta   (s1_meta),
    .out_valid (s2_valid),
    .out_data  (s2_data),
    .out_amt   (s2_amt),
    .out_meta  (s2_meta)
  );

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_err   = s2_meta.err;
  assign bus.out_zero  = s2_valid && (s2_data == '0);
  assign unused_s2     = ^{s2_amt, s2_meta.mode};

endmodule

// File: tb/tb_var_shift_unit.sv
// Scoreboarded bench: directed cases on an 8-bit unit, random traffic on a 13-bit unit.
module tb_var_shift_unit;

`ifdef VAR_SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    logic        zero;
    logic        err;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   acc8 = 0;
  int   gaps;
  bit   rnd_on;
  bit   fresh8 = 1'b1;
  exp_t q8[$];
  exp_t q13[$];
  exp_t e8, e13;

  var_shift_unit_if #(.WIDTH(8),  .AMT_W(8)) if8 ();
  var_shift_unit_if #(.WIDTH(13), .AMT_W(5)) if13 ();

  var_shift_unit #(.WIDTH(8),  .AMT_W(8)) u8  (.clk(clk), .reset(reset), .bus(if8));
  var_shift_unit #(.WIDTH(13), .AMT_W(5)) u13 (.clk(clk), .reset(reset), .bus(if13));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-level reference: each result bit is picked from its source position.
  function automatic logic [63:0] model(input logic [63:0] d, input int amt, input int m, input int w);
    logic [63:0] r = '0;
    for (int i = 0; i < w; i++) begin
      if (m == 3 && ROT_EN)      r[i] = d[(i - (amt % w) + w) % w];
      else if (m == 0 || m == 3) r[i] = (i >= amt) ? d[i - amt] : 1'b0;
      else if (m == 1)           r[i] = (i + amt < w) ? d[i + amt] : 1'b0;
      else                       r[i] = (i + amt < w) ? d[i + amt] : d[w - 1];
    end
    return r;
  endfunction

  task automatic send8(input logic [7:0] d, input logic [7:0] a, input logic [1:0] m,
                       input logic [7:0] ed, input logic ez, input logic ee, input bit lat);
    int n = 0;
    if8.in_valid = 1'b1; if8.in_data = d; if8.in_amt = a; if8.in_mode = m;
    @(negedge clk);
    while (!if8.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!if8.in_ready) chk("u8_accept_timeout", if8.in_ready, 1'b1);
    else begin
      q8.push_back('{data: 64'(ed), zero: ez, err: ee, acc: cyc, lat: lat});
      acc8++;
    end
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
  endtask

  task automatic send13(input logic [12:0] d, input logic [4:0] a, input logic [1:0] m);
    int n = 0;
    logic [63:0] r;
    r = model(64'(d), int'(a), int'(m), 13);
    if13.in_valid = 1'b1; if13.in_data = d; if13.in_amt = a; if13.in_mode = m;
    @(negedge clk);
    while (!if13.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!if13.in_ready) chk("u13_accept_timeout", if13.in_ready, 1'b1);
    else q13.push_back('{data: r, zero: (r == 0), err: (m == 2'd3) && !ROT_EN, acc: cyc, lat: 1'b0});
    @(posedge clk); #1;
    if13.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) fresh8 = 1'b1;
    else if (if8.out_valid) begin
      if (q8.size() == 0) chk("u8_stale_out", if8.out_valid, 1'b0);
      else begin
        e8 = q8[0];
        chk("u8_data", 64'(if8.out_data), e8.data);
        chk("u8_zero", 64'(if8.out_zero), 64'(e8.zero));
        chk("u8_err",  64'(if8.out_err),  64'(e8.err));
        if (fresh8 && e8.lat) chk("u8_latency", 64'(cyc - e8.acc), 64'd2);
        if (if8.out_ready) void'(q8.pop_front());
      end
      fresh8 = if8.out_ready;
    end else fresh8 = 1'b1;
  end

  always @(negedge clk) begin
    if (!reset && if13.out_valid) begin
      if (q13.size() == 0) chk("u13_stale_out", if13.out_valid, 1'b0);
      else begin
        e13 = q13[0];
        chk("u13_data", 64'(if13.out_data), e13.data);
        chk("u13_zero", 64'(if13.out_zero), 64'(e13.zero));
        chk("u13_err",  64'(if13.out_err),  64'(e13.err));
        if (if13.out_ready) void'(q13.pop_front());
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 300 && (q8.size() != 0 || q13.size() != 0); k++) @(negedge clk);
    chk("q8_drained",  q8.size(),  0);
    chk("q13_drained", q13.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    if8.in_valid = 1'b0;  if8.in_data = '0;  if8.in_amt = '0;  if8.in_mode = '0;  if8.out_ready = 1'b1;
    if13.in_valid = 1'b0; if13.in_data = '0; if13.in_amt = '0; if13.in_mode = '0; if13.out_ready = 1'b1;
    #12 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", if8.out_valid, 1'b0);
    chk("reset_out_data",  if8.out_data,  8'h00);
    chk("reset_out_zero",  if8.out_zero,  1'b0);
    chk("reset_out_err",   if8.out_err,   1'b0);
    chk("reset_in_ready",  if8.in_ready,  1'b1);
    @(posedge clk); #1;

    send8(8'hA5, 8'd1,   2'd0, 8'h4A, 1'b0, 1'b0, 1'b1);
    send8(8'hA5, 8'd7,   2'd0, 8'h80, 1'b0, 1'b0, 1'b1);
    send8(8'hA5, 8'd0,   2'd0, 8'hA5, 1'b0, 1'b0, 1'b1);
    send8(8'hA5, 8'd2,   2'd2, 8'hE9, 1'b0, 1'b0, 1'b1);
    send8(8'hA5, 8'd200, 2'd2, 8'hFF, 1'b0, 1'b0, 1'b1);
    send8(8'hA5, 8'd9,   2'd1, 8'h00, 1'b1, 1'b0, 1'b1);
`ifdef VAR_SHIFT_ROTATE_EN
    send8(8'hA5, 8'd3,  2'd3, 8'h2D, 1'b0, 1'b0, 1'b1);
    send8(8'hA5, 8'd11, 2'd3, 8'h2D, 1'b0, 1'b0, 1'b1);
`else
    send8(8'hA5, 8'd3,  2'd3, 8'h28, 1'b0, 1'b1, 1'b1);
`endif
    drain();

    // Output stalled: two ops fill the pipe, the third must wait.
    if8.out_ready = 1'b0;
    acc8 = 0;
    send8(8'h01, 8'd1, 2'd0, 8'h02, 1'b0, 1'b0, 1'b0);
    send8(8'h80, 8'd1, 2'd1, 8'h40, 1'b0, 1'b0, 1'b0);
    fork
      send8(8'h80, 8'd3, 2'd2, 8'hF0, 1'b0, 1'b0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", if8.in_ready, 1'b0);
        chk("bp_accepted",     acc8,         2);
        chk("bp_out_valid",    if8.out_valid, 1'b1);
        @(posedge clk); #1;
        if8.out_ready = 1'b1;
        gaps = 0;
        repeat (3) begin @(negedge clk); if (!if8.out_valid) gaps++; end
        chk("bp_no_gaps", gaps, 0);
      end
    join
    drain();

    // Reset mid-cycle with two ops in flight.
    if8.out_ready = 1'b0;
    send8(8'h0F, 8'd4, 2'd0, 8'hF0, 1'b0, 1'b0, 1'b0);
    send8(8'h3C, 8'd2, 2'd1, 8'h0F, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_pre_out_valid", if8.out_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_out_valid", if8.out_valid, 1'b0);
    chk("rst_out_data",  if8.out_data,  8'h00);
    chk("rst_out_zero",  if8.out_zero,  1'b0);
    chk("rst_out_err",   if8.out_err,   1'b0);
    chk("rst_in_ready",  if8.in_ready,  1'b1);
    q8.delete();
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    if8.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_stale", if8.out_valid, 1'b0);
    @(posedge clk); #1;
    send8(8'hA5, 8'd1, 2'd0, 8'h4A, 1'b0, 1'b0, 1'b1);
    drain();

    // Random traffic with random backpressure on the 13-bit unit.
    rnd_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          send13(13'($urandom_range(0, 8191)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
          if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          if13.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    if13.out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
